// File: rtl/ac_sweep_pkg.sv
// rtl/ac_sweep_pkg.sv - shared state, quadrant types, constants and LUT builder for the AC sweep DDS
package ac_sweep_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    typedef logic [1:0] quad_t;

    localparam int PIPE_LAT = 3;
    localparam logic [15:0] UNITY_AMP = 16'h8000;

    // Elaboration-time quarter-wave entry: round(32767*sin(pi/2*(i+0.5)/2^aw)) via Taylor series.
    function automatic int lut_entry(input int i, input int aw);
        real x;
        real term;
        real s;
        x    = 3.14159265358979323846 * (real'(i) + 0.5) / real'(2 ** (aw + 1));
        term = x;
        s    = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            s    = s + term;
        end
        return $rtoi(32767.0 * s + 0.5);
    endfunction

endpackage

// File: rtl/ac_sine_lut.sv
// rtl/ac_sine_lut.sv - quarter-wave sine ROM with quadrant fold and negate, 2-cycle latency
module ac_sine_lut
    import ac_sweep_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int SAMP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LUT_AW+1:0]        phase_top,
    output logic signed [SAMP_W-1:0] value
);

    logic signed [SAMP_W-1:0] rom [2**LUT_AW];

    for (genvar g = 0; g < 2**LUT_AW; g++) begin : g_rom
        localparam int VAL = lut_entry(g, LUT_AW);
        assign rom[g] = SAMP_W'(VAL);
    end

    quad_t             quad;
    logic [LUT_AW-1:0] addr;

    // Odd quadrants walk the quarter wave backwards; the upper half-cycle is negated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quad  <= '0;
            addr  <= '0;
            value <= '0;
        end else begin
            quad  <= phase_top[LUT_AW+1:LUT_AW];
            addr  <= phase_top[LUT_AW] ? ~phase_top[LUT_AW-1:0] : phase_top[LUT_AW-1:0];
            value <= quad[1] ? -rom[addr] : rom[addr];
        end
    end

endmodule

// File: rtl/ac_sweep_dds.sv
// rtl/ac_sweep_dds.sv - stepped-frequency DDS sine sweep; AC_SWEEP_LOG_EN selects geometric stepping
module ac_sweep_dds
    import ac_sweep_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int SAMP_W  = 16,
    parameter int PTS_W   = 16,
    parameter int DWELL_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     sample_en,
    input  logic [PHASE_W-1:0]       cfg_start_fcw,
    input  logic [PHASE_W-1:0]       cfg_step_fcw,
    input  logic [4:0]               cfg_log_shift,
    input  logic [PTS_W-1:0]         cfg_points,
    input  logic [DWELL_W-1:0]       cfg_dwell,
    input  logic [15:0]              cfg_amp,
    output logic                     out_valid,
    output logic signed [SAMP_W-1:0] out_sample,
    output logic [PTS_W-1:0]         point_idx,
    output logic                     point_start,
    output logic                     busy,
    output logic                     done
);

    localparam int PW = SAMP_W + 17;
    localparam logic signed [PW-1:0] SAT_HI = PW'((1 <<< (SAMP_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = -SAT_HI;

    state_t               state;
    logic [PHASE_W-1:0]   phase;
    logic [PHASE_W-1:0]   fcw;
    logic [PHASE_W-1:0]   next_fcw;
    logic [PTS_W-1:0]     point_cnt;
    logic [PTS_W-1:0]     points_q;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [DWELL_W-1:0]   dwell_q;
    logic [DWELL_W-1:0]   dwell_last;
    logic [15:0]          amp_q;

`ifdef AC_SWEEP_LOG_EN
    logic [4:0] shift_q;
    logic       unused_step;
    assign unused_step = ^cfg_step_fcw;
    assign next_fcw    = fcw + (fcw >> shift_q);
`else
    logic [PHASE_W-1:0] step_q;
    logic               unused_shift;
    assign unused_shift = ^cfg_log_shift;
    assign next_fcw     = fcw + step_q;
`endif

    logic issue;
    logic drained;
    logic [PIPE_LAT-1:0] vpipe;

    assign issue      = (state == RUN) && sample_en && !abort;
    assign drained    = ~|vpipe;
    assign out_valid  = vpipe[PIPE_LAT-1];
    assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            fcw       <= '0;
            point_cnt <= '0;
            points_q  <= '0;
            dwell_cnt <= '0;
            dwell_q   <= '0;
            amp_q     <= UNITY_AMP;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef AC_SWEEP_LOG_EN
            shift_q   <= '0;
`else
            step_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        if (cfg_points != '0) begin
                            fcw       <= cfg_start_fcw;
                            phase     <= '0;
                            point_cnt <= '0;
                            dwell_cnt <= '0;
                            points_q  <= cfg_points;
                            dwell_q   <= cfg_dwell;
                            amp_q     <= cfg_amp;
`ifdef AC_SWEEP_LOG_EN
                            shift_q   <= cfg_log_shift;
`else
                            step_q    <= cfg_step_fcw;
`endif
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                    RUN: if (sample_en) begin
                        // Phase stays continuous across points so the tone never glitches.
                        phase <= phase + fcw;
                        if (dwell_cnt == dwell_last) begin
                            dwell_cnt <= '0;
                            fcw       <= next_fcw;
                            point_cnt <= point_cnt + 1'b1;
                            if (point_cnt == points_q - 1'b1)
                                state <= FLUSH;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                    FLUSH: if (drained) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic signed [SAMP_W-1:0] lut_value;
    logic signed [SAMP_W-1:0] sat_sample;
    logic signed [PW-1:0]     product;
    logic signed [PW-1:0]     scaled;

    ac_sine_lut #(
        .LUT_AW (LUT_AW),
        .SAMP_W (SAMP_W)
    ) u_lut (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase_top (phase[PHASE_W-1 -: LUT_AW+2]),
        .value     (lut_value)
    );

    assign product = PW'(lut_value) * PW'($signed({1'b0, amp_q}));
    assign scaled  = product >>> 15;

    always_comb begin
        sat_sample = scaled[SAMP_W-1:0];
        if (scaled > SAT_HI)
            sat_sample = SAT_HI[SAMP_W-1:0];
        else if (scaled < SAT_LO)
            sat_sample = SAT_LO[SAMP_W-1:0];
    end

    logic             ps1, ps2;
    logic [PTS_W-1:0] pi1, pi2;

    // Point tags ride alongside the LUT stages so they stay aligned with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe       <= '0;
            ps1         <= 1'b0;
            ps2         <= 1'b0;
            pi1         <= '0;
            pi2         <= '0;
            out_sample  <= '0;
            point_start <= 1'b0;
            point_idx   <= '0;
        end else if (abort) begin
            vpipe       <= '0;
            ps1         <= 1'b0;
            ps2         <= 1'b0;
            pi1         <= '0;
            pi2         <= '0;
            out_sample  <= '0;
            point_start <= 1'b0;
            point_idx   <= '0;
        end else begin
            vpipe       <= {vpipe[PIPE_LAT-2:0], issue};
            ps1         <= issue && (dwell_cnt == '0);
            pi1         <= point_cnt;
            ps2         <= ps1;
            pi2         <= pi1;
            out_sample  <= vpipe[1] ? sat_sample : '0;
            point_start <= vpipe[1] & ps2;
            if (vpipe[1])
                point_idx <= pi2;
        end
    end

endmodule

// File: tb/tb_ac_sweep_dds.sv
// tb/tb_ac_sweep_dds.sv - scoreboard bench for ac_sweep_dds against a behavioural sweep model
module tb_ac_sweep_dds;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        sample_en = 1'b0;
    logic [31:0] cfg_start_fcw = '0;
    logic [31:0] cfg_step_fcw = '0;
    logic [4:0]  cfg_log_shift = '0;
    logic [15:0] cfg_points = '0;
    logic [23:0] cfg_dwell = '0;
    logic [15:0] cfg_amp = '0;
    logic               out_valid;
    logic signed [15:0] out_sample;
    logic [15:0]        point_idx;
    logic               point_start;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    ac_sweep_dds dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .sample_en     (sample_en),
        .cfg_start_fcw (cfg_start_fcw),
        .cfg_step_fcw  (cfg_step_fcw),
        .cfg_log_shift (cfg_log_shift),
        .cfg_points    (cfg_points),
        .cfg_dwell     (cfg_dwell),
        .cfg_amp       (cfg_amp),
        .out_valid     (out_valid),
        .out_sample    (out_sample),
        .point_idx     (point_idx),
        .point_start   (point_start),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        int s;
        int idx;
        bit ps;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   first_out = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint want);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    // Full-wave sine from the quarter-wave rule, then floor-scaled by amp/32768 and clamped.
    function automatic int ref_sine(input logic [31:0] ph, input int amp);
        int k, q, i, v;
        longint p;
        k = int'(ph >> 22);
        q = k / 256;
        i = k % 256;
        if (q == 1 || q == 3) i = 255 - i;
        v = $rtoi(32767.0 * $sin(3.141592653589793 * (i + 0.5) / 512.0) + 0.5);
        if (q >= 2) v = -v;
        p = longint'(v) * amp;
        p = (p >= 0) ? p / 32768 : -((-p + 32767) / 32768);
        if (p > 32767) p = 32767;
        if (p < -32767) p = -32767;
        return int'(p);
    endfunction

    task automatic push_exp(input int s, input int idx, input bit ps);
        exp_q.push_back('{s, idx, ps});
    endtask

    task automatic push_model(input logic [31:0] sf, input logic [31:0] st, input int pts, input int dw, input int amp);
        logic [31:0] f, ph;
        int d;
        f = sf;
        ph = '0;
        d = (dw == 0) ? 1 : dw;
        for (int p = 0; p < pts; p++) begin
            for (int j = 0; j < d; j++) begin
                push_exp(ref_sine(ph, amp), p, j == 0);
                ph = ph + f;
            end
            f = f + st;
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_n && out_valid) begin
            if (first_out < 0) first_out = cyc;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_sample", out_sample, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(out_sample == e.s, "sample", out_sample, e.s);
                check(point_idx == e.idx && point_start == e.ps, "point_tag",
                      point_idx * 2 + point_start, e.idx * 2 + e.ps);
            end
        end
    end

    task automatic run_sweep(input logic [31:0] sf, input logic [31:0] st, input int pts, input int dw,
                             input int amp, input int prob, input bit use_model, input bit chk_lat);
        int d0, n, t_issue;
        bit first;
        if (use_model) push_model(sf, st, pts, dw, amp);
        cfg_start_fcw = sf;
        cfg_step_fcw  = st;
        cfg_points    = 16'(pts);
        cfg_dwell     = 24'(dw);
        cfg_amp       = 16'(amp);
        d0 = done_cnt;
        first = 1'b1;
        t_issue = -1;
        first_out = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_start_fcw = $urandom;
        cfg_step_fcw  = $urandom;
        cfg_points    = 16'($urandom);
        cfg_dwell     = 24'($urandom);
        cfg_amp       = 16'($urandom);
        if (pts == 0) check(done == 1'b1 && busy == 1'b0, "zero_points_done", {done, busy}, 2);
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            sample_en = ($urandom_range(99) < prob);
            if (sample_en && first) begin
                first = 1'b0;
                t_issue = cyc;
            end
            @(posedge clk); #1;
            n++;
        end
        sample_en = 1'b0;
        check(done_cnt == d0 + 1, "done_count", done_cnt - d0, 1);
        check(exp_q.size() == 0, "all_samples_out", exp_q.size(), 0);
        check(done == 1'b0 && busy == 1'b0, "done_one_cycle", {done, busy}, 0);
        if (chk_lat) check(first_out - t_issue == 3, "latency", first_out - t_issue, 3);
        exp_q.delete();
    endtask

    initial begin
        #1;
        check({out_valid, out_sample, point_idx, point_start, busy, done} == '0, "reset_outputs",
              {out_valid, out_sample, point_idx, point_start, busy, done}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Quarter-cycle tone at unity, half and over-unity amplitude.
        push_exp(101, 0, 1); push_exp(32767, 0, 0); push_exp(-101, 0, 0); push_exp(-32767, 0, 0);
        run_sweep(32'h4000_0000, 32'h0, 1, 4, 'h8000, 100, 1'b0, 1'b1);
        push_exp(50, 0, 1); push_exp(16383, 0, 0); push_exp(-51, 0, 0); push_exp(-16384, 0, 0);
        run_sweep(32'h4000_0000, 32'h0, 1, 4, 'h4000, 100, 1'b0, 1'b0);
        push_exp(201, 0, 1); push_exp(32767, 0, 0); push_exp(-202, 0, 0); push_exp(-32767, 0, 0);
        run_sweep(32'h4000_0000, 32'h0, 1, 4, 'hFFFF, 100, 1'b0, 1'b0);

        // Point stepping, zero points, dwell zero.
        run_sweep(32'h4000_0000, 32'h1000_0000, 3, 2, 'h8000, 100, 1'b1, 1'b0);
        run_sweep(32'h4000_0000, 32'h0, 0, 4, 'h8000, 100, 1'b1, 1'b0);
        run_sweep(32'h0123_4567, 32'h0800_0000, 3, 0, 'h8000, 70, 1'b1, 1'b0);

        // sample_en while idle must produce nothing.
        sample_en = 1'b1;
        repeat (8) @(posedge clk);
        #1 sample_en = 1'b0;
        check(busy == 1'b0, "idle_ignores_sample_en", busy, 0);

        for (int t = 0; t < 25; t++) begin
            run_sweep($urandom, $urandom, $urandom_range(1, 5), $urandom_range(0, 6),
                      (t % 4 == 0) ? 'h8000 : $urandom_range(0, 65535), $urandom_range(30, 100), 1'b1, 1'b0);
        end

        // Abort in point 1 of 3, coincident with start.
        push_model(32'h0400_0000, 32'h0400_0000, 3, 4, 'h8000);
        cfg_start_fcw = 32'h0400_0000;
        cfg_step_fcw  = 32'h0400_0000;
        cfg_points    = 16'd3;
        cfg_dwell     = 24'd4;
        cfg_amp       = 16'h8000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sample_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        begin
            int d0;
            d0 = done_cnt;
            abort = 1'b1;
            start = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
            exp_q.delete();
            check(busy == 1'b0 && out_valid == 1'b0 && out_sample == 0, "abort_clears",
                  {busy, out_valid, out_sample}, 0);
            repeat (8) @(posedge clk);
            #1 sample_en = 1'b0;
            check(done_cnt == d0, "abort_no_done", done_cnt - d0, 0);
        end
        run_sweep(32'h0400_0000, 32'h0400_0000, 3, 4, 'h8000, 100, 1'b1, 1'b0);

        // Asynchronous reset mid-run.
        push_model(32'h0100_0000, 32'h0010_0000, 4, 8, 'h8000);
        cfg_start_fcw = 32'h0100_0000;
        cfg_step_fcw  = 32'h0010_0000;
        cfg_points    = 16'd4;
        cfg_dwell     = 24'd8;
        cfg_amp       = 16'h8000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sample_en = 1'b1;
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        exp_q.delete();
        sample_en = 1'b0;
        check({out_valid, out_sample, point_idx, point_start, busy, done} == '0, "async_reset_outputs",
              {out_valid, out_sample, point_idx, point_start, busy, done}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_sweep(32'h4000_0000, 32'h0, 1, 4, 'h8000, 100, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
